// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: deglitched PS/2 device-to-host frame receiver with error strobes and timeout
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] dataout,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          state;
  logic [1:0]      clk_sync, dat_sync;
  logic            filt_clk, filt_prev, par_bit;
  logic [7:0]      fcnt, shreg;
  logic [2:0]      bitcnt;
  logic [TW-1:0]   tcnt;
  logic            fall, bit_in, expired;
  assign fall    = filt_prev & ~filt_clk;
  assign bit_in  = dat_sync[1];
  assign expired = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // two-flop synchronisers for the asynchronous pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], kbd_clk};
      dat_sync <= {dat_sync[0], kbd_data};
    end
  // filtered clock only follows the synced pin after FILTER_LEN stable samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) fcnt <= '0;
      else if (fcnt == 8'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        fcnt     <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  // frame state machine: shifts bits on each filtered falling edge, decides outcome at stop bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      tcnt       <= '0;
      par_bit    <= 1'b0;
      dataout    <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (expired) begin
        state     <= IDLE;
        busy      <= 1'b0;
        shreg     <= '0;
        bitcnt    <= '0;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
        if (fall)
          case (state)
            IDLE:
              if (!bit_in) begin
                state  <= DATA;
                busy   <= 1'b1;
                bitcnt <= '0;
              end
            DATA: begin
              shreg  <= {bit_in, shreg[7:1]};
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par_bit <= bit_in;
              state   <= STOP;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!bit_in) frame_err <= 1'b1;
              else if (^shreg ^ par_bit) begin
                dataout    <= shreg;
                data_valid <= 1'b1;
              end else parity_err <= 1'b1;
            end
          endcase
      end
    end
endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- Front-end PS/2 device-to-host receiver for the keyboard path. Its outputs feed the F0 release-code filter, which fills the 16-deep scan-code FIFO read by PicoBlaze.
- Synchronises and deglitches the raw kbd_clk/kbd_data pins, then deframes 11-bit PS/2 frames: start, 8 data bits LSB first, odd parity, stop.
- Presents each good byte with a one-cycle strobe. Flags bad frames and recovers from stalled ones by timeout.

Parameters:
- FILTER_LEN, 8: consecutive identical clk samples needed before the filtered kbd_clk changes value (range 2..255).
- TIMEOUT_CYCLES, 5000: clk cycles with no falling kbd_clk edge, while a frame is open, before the frame is aborted (100 us at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- kbd_clk  input  1  raw PS/2 clock pin, asynchronous.
- kbd_data  input  1  raw PS/2 data pin, asynchronous.
- dataout  output  8  last correctly received scan code.
- data_valid  output  1  one-cycle strobe: dataout updated with a new byte.
- parity_err  output  1  one-cycle strobe: frame rejected for parity.
- frame_err  output  1  one-cycle strobe: frame rejected for bad start or stop bit, or for timeout.
- busy  output  1  high while a frame is open (state is not IDLE).

Behaviour:
- Interface: single clock domain on clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - 2-FF synchronisers for kbd_clk and kbd_data reset to 1.
  - Filtered clk resets to 1; filter counter to 0.
  - State IDLE; shift register 0x00; bit counter 0; timeout counter 0.
  - dataout 0x00; data_valid, parity_err, frame_err, busy all 0.
- Deglitch filter:
  - Counter increments while the synced clk differs from the filtered clk, and clears when they match.
  - When the counter reaches FILTER_LEN-1 with the difference still present, the filtered clk takes the synced value and the counter clears.
- fall: one-cycle flag, set when the previous filtered clk is 1 and the current one is 0. Data is sampled from synced kbd_data in the fall cycle.
- FSM transitions, all taken on fall:
  - IDLE: sampled 0 (start bit) -> DATA with bit counter 0. Sampled 1 -> stay IDLE, no error.
  - DATA: shift the bit into the MSB, shift register shifts right, so the first bit ends up in bit 0. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: always -> IDLE. The outcome is decided here (below).
- STOP outcome, strobe in the cycle after the fall:
  - Stop bit = 1 and (XOR of the 8 data bits ^ parity bit) = 1: dataout <= byte, data_valid = 1.
  - Stop bit = 1, parity fails: parity_err = 1, dataout unchanged.
  - Stop bit = 0: frame_err = 1, dataout unchanged, whatever the parity.
  - Exactly one strobe per completed frame; strobes never overlap.
- Timeout:
  - In any non-IDLE state the counter increments each cycle and clears on fall.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err = 1 for one cycle, shift register and bit counter cleared, dataout unchanged.
  - If fall and timeout expiry coincide, fall wins and no timeout occurs.
- busy = (state != IDLE), registered with the state.
- Asserting rst_n low mid-frame aborts immediately to reset values with no strobe. After release, the first fall seen is treated as a possible start bit.
- Host-to-device (inhibit or transmit) is not supported. Held-low clock periods are handled by the timeout.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz PS/2 clock -> exactly one data_valid, dataout=0x1C, no error strobes, busy low afterwards.
- Back-to-back 0xF0 (parity 1) then 0x1C, 50 us inter-frame gap -> two data_valid strobes, dataout 0xF0 then 0x1C.
- 0x1C sent with parity 1 -> one parity_err pulse, dataout keeps its previous value, no data_valid.
- 0x00 with parity 1 and stop bit 0 -> frame_err, no data_valid. Then a good 0x5A frame (parity 1) -> data_valid, dataout=0x5A.
- Clock stops after 4 data bits -> after TIMEOUT_CYCLES cycles: frame_err, busy=0. A following 0x1C frame is received correctly.
- 3-cycle low glitches on kbd_clk during IDLE and mid-frame -> no state change. Then rst_n pulsed low mid-frame -> all outputs 0, state IDLE.
